// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the branch predictor.
//   OPCODE_*     : opcode[6:2] encodings of control-transfer instructions
//   BP_CTR_INIT  : counter value after reset (weakly not-taken)
//   BP_CTR_ALLOC : counter value for a freshly allocated branch (weakly taken)
//   ctr_next     : 2-bit saturating counter update
package branch_predictor_pkg;

  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;

  localparam logic [1:0] BP_CTR_INIT   = 2'b01;
  localparam logic [1:0] BP_CTR_ALLOC  = 2'b10;
  localparam logic [1:0] BP_CTR_JAL    = 2'b11;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    r = ctr;
    if (taken) begin
      if (ctr != 2'b11) r = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) r = ctr - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: 2**IDX_BITS entries of {valid, tag, target, ctr}.
//   clk, rst          : clock, synchronous active-high reset (clears all entries)
//   ra_* / rb_*       : two asynchronous read ports (fetch lookup, execute lookup)
//   we, waddr, wdata  : synchronous write port, wdata = {tag, target, ctr};
//                       a written entry always becomes valid
// Reset wins over a write in the same cycle.
module btb_table
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_BITS-1:0]    ra_addr,
  output logic                   ra_valid,
  output logic [TAG_BITS-1:0]    ra_tag,
  output logic [31:0]            ra_target,
  output logic [1:0]             ra_ctr,
  input  logic [IDX_BITS-1:0]    rb_addr,
  output logic                   rb_valid,
  output logic [TAG_BITS-1:0]    rb_tag,
  output logic [31:0]            rb_target,
  output logic [1:0]             rb_ctr,
  input  logic                   we,
  input  logic [IDX_BITS-1:0]    waddr,
  input  logic [TAG_BITS+33:0]   wdata
);

  localparam int N = 1 << IDX_BITS;

  logic                valid_q  [N];
  logic [TAG_BITS-1:0] tag_q    [N];
  logic [31:0]         target_q [N];
  logic [1:0]          ctr_q    [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BP_CTR_INIT;
      end
    end else if (we) begin
      valid_q[waddr]  <= 1'b1;
      tag_q[waddr]    <= wdata[TAG_BITS+33:34];
      target_q[waddr] <= wdata[33:2];
      ctr_q[waddr]    <= wdata[1:0];
    end
  end

  assign ra_valid  = valid_q[ra_addr];
  assign ra_tag    = tag_q[ra_addr];
  assign ra_target = target_q[ra_addr];
  assign ra_ctr    = ctr_q[ra_addr];

  assign rb_valid  = valid_q[rb_addr];
  assign rb_tag    = tag_q[rb_addr];
  assign rb_target = target_q[rb_addr];
  assign rb_ctr    = ctr_q[rb_addr];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor with execute-stage resolution checking.
//   clk, rst                 : clock, synchronous active-high reset
//   f_pc                     : fetch PC, looked up combinationally
//   pred_hit/taken/target    : prediction for f_pc (target 0 on miss)
//   u_valid .. u_pred_target : resolved branch/jump from execute
//   mispredict, redirect_pc  : flush request and correct next PC (combinational)
//   branch_cnt, mispred_cnt  : wrapping performance counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_hit,
  input  logic        u_valid,
  input  logic [31:0] u_pc,
  input  logic [4:0]  u_opcode,
  input  logic        u_taken,
  input  logic [31:0] u_target,
  input  logic        u_pred_taken,
  input  logic [31:0] u_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int TAG_LO = IDX_BITS + 2;
  localparam int TAG_HI = IDX_BITS + TAG_BITS + 1;

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign f_tag = f_pc[TAG_HI:TAG_LO];
  assign u_idx = u_pc[IDX_BITS+1:2];
  assign u_tag = u_pc[TAG_HI:TAG_LO];

  // Bits above the tag and the byte offset never take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[31:TAG_HI+1], f_pc[1:0], u_pc[31:TAG_HI+1], u_pc[1:0]};

  logic                f_valid, u_rvalid;
  logic [TAG_BITS-1:0] f_rtag, u_rtag;
  logic [31:0]         f_rtarget, u_rtarget;
  logic [1:0]          f_rctr, u_rctr;

  logic                we;
  logic [31:0]         wtarget;
  logic [1:0]          wctr;

  btb_table #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .ra_addr   (f_idx),
    .ra_valid  (f_valid),
    .ra_tag    (f_rtag),
    .ra_target (f_rtarget),
    .ra_ctr    (f_rctr),
    .rb_addr   (u_idx),
    .rb_valid  (u_rvalid),
    .rb_tag    (u_rtag),
    .rb_target (u_rtarget),
    .rb_ctr    (u_rctr),
    .we        (we),
    .waddr     (u_idx),
    .wdata     ({u_tag, wtarget, wctr})
  );

  // Fetch-side prediction
  assign pred_hit    = f_valid && (f_rtag == f_tag);
  assign pred_taken  = pred_hit && f_rctr[1];
  assign pred_target = pred_hit ? f_rtarget : 32'd0;

  // Resolution check
  assign mispredict  = u_valid && ((u_taken != u_pred_taken) ||
                                   (u_taken && (u_target != u_pred_target)));
  assign redirect_pc = u_taken ? u_target : (u_pc + 32'd4);

  // Training decision; the table is re-read at u_pc so hit/miss reflects
  // the stored state, not whatever prediction was carried down the pipe.
  logic u_hit;
  assign u_hit = u_rvalid && (u_rtag == u_tag);

  always_comb begin
    we      = 1'b0;
    wtarget = u_rtarget;
    wctr    = u_rctr;
    if (u_valid) begin
      case (u_opcode)
        OPCODE_BRANCH: begin
          if (u_hit) begin
            we   = 1'b1;
            wctr = ctr_next(u_rctr, u_taken);
            if (u_taken) wtarget = u_target;
          end else if (u_taken) begin
            we      = 1'b1;
            wctr    = BP_CTR_ALLOC;
            wtarget = u_target;
          end
        end
        OPCODE_JAL: begin
          we      = 1'b1;
          wctr    = BP_CTR_JAL;
          wtarget = u_target;
        end
        default: we = 1'b0;
      endcase
    end
  end

  // Performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else if (u_valid) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule
